pll_clken_gen: RTL and testbench

//   Parametrised N-channel fractional clock-enable generator. Runs on the board reference clock.

---
 rtl/pll_clken_pkg.sv | 20 ++
 rtl/pll_clken_if.sv | 23 ++
 rtl/pll_clken_gen_phase_acc.sv | 37 +++
 rtl/pll_clken_gen.sv | 94 +++++++++
 tb/tb_pll_clken_gen.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/pll_clken_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
// freq_to_inc computes an accumulator increment from a reference and target frequency at elaboration.
package pll_clken_pkg;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // inc = out_hz * 2^acc_w / ref_hz. The 128-bit intermediate keeps the shift from overflowing.
    function automatic logic [63:0] freq_to_inc(input longint unsigned ref_hz,
                                                input longint unsigned out_hz,
                                                input int acc_w);
        logic [127:0] tmp;
        tmp = 128'(out_hz);
        tmp = (tmp << acc_w) / 128'(ref_hz);
        return tmp[63:0];
    endfunction

endpackage

// File: rtl/pll_clken_if.sv
// Reconfiguration handshake plus enable/lock outputs of pll_clken_gen.
interface pll_clken_if #(
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 32
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [3:0]          cfg_chan;
    logic [ACC_W-1:0]    cfg_inc;
    logic                cfg_err;
    logic [CHANNELS-1:0] clken;
    logic                locked;

    modport master (
        output cfg_valid, cfg_chan, cfg_inc,
        input  cfg_ready, cfg_err, clken, locked
    );

    modport slave (
        input  cfg_valid, cfg_chan, cfg_inc,
        output cfg_ready, cfg_err, clken, locked
    );
endinterface

// File: rtl/pll_clken_gen_phase_acc.sv
// One channel of the enable generator: phase accumulator whose carry-out is the enable pulse.
module pll_phase_acc #(
    parameter int ACC_W = 32
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    input  logic [ACC_W-1:0] inc_init,
    output logic             pulse
);
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;

    always_ff @(posedge refclk) begin
        if (rst) begin
            acc   <= '0;
            inc   <= inc_init;
            pulse <= 1'b0;
        end else begin
            if (load) begin
                inc <= load_inc;
            end
            // clr phase-aligns all channels; it outranks en on a reconfig edge.
            if (clr) begin
                acc   <= '0;
                pulse <= 1'b0;
            end else if (en) begin
                {pulse, acc} <= {1'b0, acc} + {1'b0, inc};
            end else begin
                pulse <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/pll_clken_gen.sv
// N-channel fractional clock-enable generator with a PLL-style lock sequence and runtime retuning.
// state     | meaning
// ST_SETTLE | counting LOCK_CYCLES edges; accumulators frozen, clken/locked low
// ST_LOCKED | accumulators running, locked high, cfg requests accepted
module pll_clken_gen
    import pll_clken_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 16,
    parameter logic [CHANNELS*ACC_W-1:0] INC_INIT = {32'h4000_0000, 32'h8000_0000}
) (
    input  logic       refclk,
    input  logic       rst,
    pll_clken_if.slave bus
);
    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                locked_q, locked_nxt;
    logic                err_q, err_nxt;
    logic                xfer, chan_ok, xfer_ok, xfer_err;
    logic [CHANNELS-1:0] pulse;

    assign bus.cfg_ready = (state == ST_LOCKED);
    assign xfer          = bus.cfg_valid && bus.cfg_ready;
    assign chan_ok       = ({1'b0, bus.cfg_chan} < 5'(CHANNELS));
    assign xfer_ok       = xfer && chan_ok;
    assign xfer_err      = xfer && !chan_ok;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state    <= ST_SETTLE;
            cnt      <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            locked_q <= locked_nxt;
            err_q    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        locked_nxt = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            ST_SETTLE: begin
                if (cnt == CNT_LAST) begin
                    state_nxt  = ST_LOCKED;
                    locked_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                locked_nxt = 1'b1;
                if (xfer_ok) begin
                    state_nxt  = ST_SETTLE;
                    cnt_nxt    = '0;
                    locked_nxt = 1'b0;
                end else if (xfer_err) begin
                    err_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_SETTLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pll_phase_acc #(.ACC_W(ACC_W)) u_acc (
            .refclk   (refclk),
            .rst      (rst),
            .en       (bus.cfg_ready),
            .clr      (xfer_ok),
            .load     (xfer_ok && (bus.cfg_chan == 4'(i))),
            .load_inc (bus.cfg_inc),
            .inc_init (INC_INIT[i*ACC_W +: ACC_W]),
            .pulse    (pulse[i])
        );
    end

    assign bus.clken   = pulse;
    assign bus.locked  = locked_q;
    assign bus.cfg_err = err_q;
endmodule

// File: tb/tb_pll_clken_gen.sv
// Directed bench: a default 32-bit instance for lock/reconfig/reset, and an 8-bit instance for fractional spacing.
module tb_pll_clken_gen;
    import pll_clken_pkg::*;

    logic refclk = 1'b0;
    always #5 refclk = ~refclk;

    logic rst_a;
    logic rst_b8;

    pll_clken_if #(.CHANNELS(2), .ACC_W(32)) bus_a ();
    pll_clken_if #(.CHANNELS(2), .ACC_W(8))  bus_b ();

    pll_clken_gen dut_a (
        .refclk (refclk),
        .rst    (rst_a),
        .bus    (bus_a)
    );

    pll_clken_gen #(
        .CHANNELS    (2),
        .ACC_W       (8),
        .LOCK_CYCLES (4),
        .INC_INIT    ({8'd0, 8'd3})
    ) dut_b (
        .refclk (refclk),
        .rst    (rst_b8),
        .bus    (bus_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected clken for channels pulsing every d0 / d1 locked cycles starting from acc=0.
    function automatic logic [1:0] pat(input int n, input int d0, input int d1);
        return {logic'((n % d1) == 0), logic'((n % d0) == 0)};
    endfunction

    task automatic relock_a(input string tag);
        for (int s = 1; s <= 16; s++) begin
            step();
            check({tag, "_locked"}, 64'(bus_a.locked), 64'(s == 16));
            check({tag, "_ready"}, 64'(bus_a.cfg_ready), 64'(s == 16));
        end
    endtask

    task automatic run_a(input string tag, input int cycles, input int d0, input int d1);
        for (int n = 1; n <= cycles; n++) begin
            step();
            check({tag, "_clken"}, 64'(bus_a.clken), 64'(pat(n, d0, d1)));
        end
    endtask

    initial begin
        int c0, c1, last, first;
        logic [1:0] exp_b;

        rst_a           = 1'b1;
        rst_b8          = 1'b1;
        bus_a.cfg_valid = 1'b0;
        bus_a.cfg_chan  = 4'd0;
        bus_a.cfg_inc   = 32'd0;
        bus_b.cfg_valid = 1'b0;
        bus_b.cfg_chan  = 4'd0;
        bus_b.cfg_inc   = 8'd0;

        check("freq_to_inc", freq_to_inc(100, 25, 32), 64'h4000_0000);

        repeat (3) step();
        check("rst_locked", 64'(bus_a.locked), 64'd0);
        check("rst_clken", 64'(bus_a.clken), 64'd0);
        check("rst_ready", 64'(bus_a.cfg_ready), 64'd0);
        check("rst_err", 64'(bus_a.cfg_err), 64'd0);

        // Lock sequence and default rates: ch0 f/2, ch1 f/4.
        rst_a = 1'b0;
        relock_a("lock1");
        c0 = 0;
        c1 = 0;
        for (int n = 1; n <= 1000; n++) begin
            step();
            check("def_clken", 64'(bus_a.clken), 64'(pat(n, 2, 4)));
            c0 += int'(bus_a.clken[0]);
            c1 += int'(bus_a.clken[1]);
        end
        check("def_cnt0", 64'(c0), 64'd500);
        check("def_cnt1", 64'(c1), 64'd250);
        check("def_locked", 64'(bus_a.locked), 64'd1);

        // Out-of-range channel: error pulse, no relock, pattern continues from cycle 1001.
        bus_a.cfg_valid = 1'b1;
        bus_a.cfg_chan  = 4'd5;
        bus_a.cfg_inc   = 32'h1234_5678;
        step();
        bus_a.cfg_valid = 1'b0;
        check("err_pulse", 64'(bus_a.cfg_err), 64'd1);
        check("err_locked", 64'(bus_a.locked), 64'd1);
        check("err_clken", 64'(bus_a.clken), 64'(pat(1001, 2, 4)));
        for (int n = 1002; n <= 1008; n++) begin
            step();
            check("err_clr", 64'(bus_a.cfg_err), 64'd0);
            check("err_run", 64'(bus_a.clken), 64'(pat(n, 2, 4)));
            check("err_lk", 64'(bus_a.locked), 64'd1);
        end

        // Reconfigure ch1 to f/8.
        check("rc_ready", 64'(bus_a.cfg_ready), 64'd1);
        bus_a.cfg_valid = 1'b1;
        bus_a.cfg_chan  = 4'd1;
        bus_a.cfg_inc   = 32'h2000_0000;
        step();
        bus_a.cfg_valid = 1'b0;
        check("rc_locked", 64'(bus_a.locked), 64'd0);
        check("rc_clken", 64'(bus_a.clken), 64'd0);
        check("rc_ready0", 64'(bus_a.cfg_ready), 64'd0);
        relock_a("rc");
        run_a("rc", 64, 2, 8);

        // Request held through SETTLE: only accepted on the first locked cycle.
        bus_a.cfg_valid = 1'b1;
        bus_a.cfg_chan  = 4'd0;
        bus_a.cfg_inc   = 32'h1000_0000;
        step();
        check("hold_x1", 64'(bus_a.locked), 64'd0);
        bus_a.cfg_inc = 32'h4000_0000;
        relock_a("hold");
        step();
        bus_a.cfg_valid = 1'b0;
        check("hold_x2", 64'(bus_a.locked), 64'd0);
        check("hold_x2rdy", 64'(bus_a.cfg_ready), 64'd0);
        check("hold_x2clk", 64'(bus_a.clken), 64'd0);
        relock_a("hold2");
        run_a("hold", 32, 4, 8);

        // Reset during SETTLE after a reconfig restores the initial increments.
        bus_a.cfg_valid = 1'b1;
        bus_a.cfg_chan  = 4'd1;
        bus_a.cfg_inc   = 32'h1000_0000;
        step();
        bus_a.cfg_valid = 1'b0;
        check("mr_x", 64'(bus_a.locked), 64'd0);
        repeat (5) step();
        rst_a = 1'b1;
        step();
        check("mr_locked", 64'(bus_a.locked), 64'd0);
        check("mr_clken", 64'(bus_a.clken), 64'd0);
        check("mr_ready", 64'(bus_a.cfg_ready), 64'd0);
        check("mr_err", 64'(bus_a.cfg_err), 64'd0);
        rst_a = 1'b0;
        relock_a("mr");
        run_a("mr", 16, 2, 4);

        // 8-bit instance: ch0 inc=3, ch1 inc=0, LOCK_CYCLES=4.
        rst_b8 = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            check("b_locked", 64'(bus_b.locked), 64'(e == 4));
        end
        c0    = 0;
        c1    = 0;
        last  = 0;
        first = 0;
        for (int n = 1; n <= 256; n++) begin
            step();
            exp_b = {1'b0, logic'(((3 * n) / 256) != ((3 * (n - 1)) / 256))};
            check("b_clken", 64'(bus_b.clken), 64'(exp_b));
            if (bus_b.clken[0]) begin
                c0++;
                if (last == 0) begin
                    first = n;
                end else begin
                    check("b_spacing", 64'(((n - last) == 85) || ((n - last) == 86)), 64'd1);
                end
                last = n;
            end
            c1 += int'(bus_b.clken[1]);
        end
        check("b_first", 64'(first), 64'd86);
        check("b_cnt0", 64'(c0), 64'd3);
        check("b_cnt1", 64'(c1), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
